// File: rtl/dds_ctrl_pkg.sv
// Shared definitions for the DDS sweep controller and the DDS cores it drives.
package dds_ctrl_pkg;

    // Default widths, shared with the DDS phase-accumulator cores.
    localparam int FRE_W_DEF   = 25;
    localparam int PH_W_DEF    = 12;
    localparam int DWELL_W_DEF = 24;

    // Sweep sequencer states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DWELL = 3'd2,
        S_STEP  = 3'd3,
        S_FIN   = 3'd4
    } sweep_state_t;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Per-point dwell timer: loadable down-counter; a dwell of 0 is clamped to 1.
// The counter holds the number of cycles left on the current point,
// including the present one, so expire is high on the last cycle of a point.
import dds_ctrl_pkg::*;

module dds_dwell_cnt #(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic               reload,
    input  logic               clear,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

    logic [DWELL_W-1:0] cnt;

    // Load the clamped dwell on a new point, otherwise count down to 1 and hold.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= (dwell == '0) ? CNT_ONE : dwell;
        end else if (cnt > CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    assign expire = (cnt == CNT_ONE);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency sweep sequencer feeding a DDS core's fre / init_phase /
// phase_rst inputs. All outputs are registered.
//
// Request semantics: start and abort are single-cycle requests sampled on
// every clk_100M edge. start is accepted only in IDLE and only when abort is
// low; abort forces IDLE from any other state and wins over a dwell expiry.
// There is no back-pressure: busy reports the sweep in progress, step_tick
// marks each fre load, done marks the end of a single (non-looping) sweep.
import dds_ctrl_pkg::*;

module dds_sweep_ctrl #(
    parameter int FRE_W   = FRE_W_DEF,
    parameter int PH_W    = PH_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk_100M,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_en,
    input  logic [FRE_W-1:0]   f_start,
    input  logic [FRE_W-1:0]   f_stop,
    input  logic [FRE_W-1:0]   f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [PH_W-1:0]    phase_cfg,
    output logic [FRE_W-1:0]   fre,
    output logic [PH_W-1:0]    init_phase,
    output logic               phase_rst,
    output logic               busy,
    output logic               step_tick,
    output logic               done
);

    // Current sequencer state; kept as a named signal so checkers can bind to it.
    sweep_state_t state, state_nxt;

    // Configuration captured at start; inputs are ignored while a sweep runs.
    logic [FRE_W-1:0]   sh_start, sh_stop, sh_step;
    logic [DWELL_W-1:0] sh_dwell;
    logic [PH_W-1:0]    sh_phase;
    logic               sh_loop, sh_up;

    // Next-cycle values of the registered outputs.
    logic [FRE_W-1:0] fre_nxt;
    logic [PH_W-1:0]  init_phase_nxt;
    logic             phase_rst_nxt, busy_nxt, step_tick_nxt, done_nxt;
    logic             latch_cfg, cnt_reload, cnt_clear;

    // Dwell timer control; the very first point loads dwell straight from the input.
    logic               dwell_expire;
    logic [DWELL_W-1:0] dwell_load;

    // Next-point arithmetic carried one bit wider to expose carry/borrow.
    logic [FRE_W:0]   sum_up, diff_dn;
    logic [FRE_W-1:0] nxt_fre;
    logic             last_pt;

    assign dwell_load = (state == S_IDLE) ? dwell : sh_dwell;

    dds_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
        .clk_100M (clk_100M),
        .rst_n    (rst_n),
        .reload   (cnt_reload),
        .clear    (cnt_clear),
        .dwell    (dwell_load),
        .expire   (dwell_expire)
    );

    // Compute the next frequency and decide whether the current point is the last.
    always_comb begin
        sum_up  = {1'b0, fre} + {1'b0, sh_step};
        diff_dn = {1'b0, fre} - {1'b0, sh_step};
        if (sh_up) begin
            nxt_fre = sum_up[FRE_W-1:0];
            last_pt = sum_up[FRE_W] || (sum_up[FRE_W-1:0] > sh_stop);
        end else begin
            nxt_fre = diff_dn[FRE_W-1:0];
            last_pt = diff_dn[FRE_W] || (diff_dn[FRE_W-1:0] < sh_stop);
        end
        if (sh_step == '0) begin
            last_pt = 1'b1;
        end
    end

    // Next-state and next-output logic. A point's dwell starts on the cycle
    // fre changes (LOAD or STEP), so expiry is honoured in LOAD/STEP/DWELL alike.
    always_comb begin
        state_nxt      = state;
        fre_nxt        = fre;
        init_phase_nxt = init_phase;
        phase_rst_nxt  = 1'b0;
        step_tick_nxt  = 1'b0;
        done_nxt       = 1'b0;
        busy_nxt       = busy;
        latch_cfg      = 1'b0;
        cnt_reload     = 1'b0;
        cnt_clear      = 1'b0;

        unique case (state)
            S_IDLE: begin
                busy_nxt = 1'b0;
                if (start && !abort) begin
                    latch_cfg      = 1'b1;
                    cnt_reload     = 1'b1;
                    state_nxt      = S_LOAD;
                    fre_nxt        = f_start;
                    init_phase_nxt = phase_cfg;
                    phase_rst_nxt  = 1'b1;
                    step_tick_nxt  = 1'b1;
                    busy_nxt       = 1'b1;
                end
            end
            S_LOAD, S_STEP, S_DWELL: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    fre_nxt   = '0;
                    busy_nxt  = 1'b0;
                    cnt_clear = 1'b1;
                end else if (dwell_expire) begin
                    if (!last_pt) begin
                        state_nxt     = S_STEP;
                        fre_nxt       = nxt_fre;
                        step_tick_nxt = 1'b1;
                        cnt_reload    = 1'b1;
                    end else if (sh_loop) begin
                        state_nxt      = S_LOAD;
                        fre_nxt        = sh_start;
                        init_phase_nxt = sh_phase;
                        phase_rst_nxt  = 1'b1;
                        step_tick_nxt  = 1'b1;
                        cnt_reload     = 1'b1;
                    end else begin
                        state_nxt = S_FIN;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end else begin
                    state_nxt = S_DWELL;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                if (abort) begin
                    fre_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                fre_nxt   = '0;
                busy_nxt  = 1'b0;
                cnt_clear = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs toward the DDS core.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            fre        <= '0;
            init_phase <= '0;
            phase_rst  <= 1'b0;
            busy       <= 1'b0;
            step_tick  <= 1'b0;
            done       <= 1'b0;
        end else begin
            fre        <= fre_nxt;
            init_phase <= init_phase_nxt;
            phase_rst  <= phase_rst_nxt;
            busy       <= busy_nxt;
            step_tick  <= step_tick_nxt;
            done       <= done_nxt;
        end
    end

    // Capture the sweep configuration and direction when a sweep is accepted.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            sh_start <= '0;
            sh_stop  <= '0;
            sh_step  <= '0;
            sh_dwell <= '0;
            sh_phase <= '0;
            sh_loop  <= 1'b0;
            sh_up    <= 1'b0;
        end else if (latch_cfg) begin
            sh_start <= f_start;
            sh_stop  <= f_stop;
            sh_step  <= f_step;
            sh_dwell <= dwell;
            sh_phase <= phase_cfg;
            sh_loop  <= loop_en;
            sh_up    <= (f_start <= f_stop);
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: hand-computed per-cycle expectations.
module tb_dds_sweep_ctrl;

    localparam int FRE_W   = 25;
    localparam int PH_W    = 12;
    localparam int DWELL_W = 24;

    // ---------------- clock / reset ----------------
    logic clk_100M = 1'b0;
    logic rst_n;
    always #5 clk_100M = ~clk_100M;

    logic               start, abort, loop_en;
    logic [FRE_W-1:0]   f_start, f_stop, f_step;
    logic [DWELL_W-1:0] dwell;
    logic [PH_W-1:0]    phase_cfg;
    logic [FRE_W-1:0]   fre;
    logic [PH_W-1:0]    init_phase;
    logic               phase_rst, busy, step_tick, done;

    int n_checks = 0;
    int n_errors = 0;

    dds_sweep_ctrl #(.FRE_W(FRE_W), .PH_W(PH_W), .DWELL_W(DWELL_W)) dut (
        .clk_100M   (clk_100M),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .loop_en    (loop_en),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_step     (f_step),
        .dwell      (dwell),
        .phase_cfg  (phase_cfg),
        .fre        (fre),
        .init_phase (init_phase),
        .phase_rst  (phase_rst),
        .busy       (busy),
        .step_tick  (step_tick),
        .done       (done)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Check all per-cycle outputs at the current negedge, then advance one cycle.
    task automatic cyc(input string tag, input logic [31:0] f_e, input logic st_e,
                       input logic pr_e, input logic b_e, input logic d_e);
        chk({tag, ".fre"},       32'(fre),       f_e);
        chk({tag, ".step_tick"}, 32'(step_tick), 32'(st_e));
        chk({tag, ".phase_rst"}, 32'(phase_rst), 32'(pr_e));
        chk({tag, ".busy"},      32'(busy),      32'(b_e));
        chk({tag, ".done"},      32'(done),      32'(d_e));
        @(negedge clk_100M);
    endtask

    // ---------------- driver ----------------
    task automatic set_cfg(input logic [FRE_W-1:0] fs, input logic [FRE_W-1:0] fp,
                           input logic [FRE_W-1:0] st, input logic [DWELL_W-1:0] dw,
                           input logic lp, input logic [PH_W-1:0] ph);
        f_start   = fs;
        f_stop    = fp;
        f_step    = st;
        dwell     = dw;
        loop_en   = lp;
        phase_cfg = ph;
    endtask

    // Pulse start for one cycle; returns at the negedge of the first LOAD cycle.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg('0, '0, '0, '0, 1'b0, '0);

        // Reset state
        #12;
        chk("rst.fre",        32'(fre),        32'd0);
        chk("rst.init_phase", 32'(init_phase), 32'd0);
        chk("rst.phase_rst",  32'(phase_rst),  32'd0);
        chk("rst.busy",       32'(busy),       32'd0);
        chk("rst.step_tick",  32'(step_tick),  32'd0);
        chk("rst.done",       32'(done),       32'd0);
        @(negedge clk_100M);
        rst_n = 1'b1;
        @(negedge clk_100M);

        // 1: up-sweep 1000 -> 1250 step 100, dwell 3
        set_cfg(25'd1000, 25'd1250, 25'd100, 24'd3, 1'b0, 12'h5A5);
        pulse_start();
        chk("s1.init_phase", 32'(init_phase), 32'h5A5);
        cyc("s1c1", 1000, 1, 1, 1, 0);
        cyc("s1c2", 1000, 0, 0, 1, 0);
        cyc("s1c3", 1000, 0, 0, 1, 0);
        cyc("s1c4", 1100, 1, 0, 1, 0);
        cyc("s1c5", 1100, 0, 0, 1, 0);
        cyc("s1c6", 1100, 0, 0, 1, 0);
        cyc("s1c7", 1200, 1, 0, 1, 0);
        cyc("s1c8", 1200, 0, 0, 1, 0);
        cyc("s1c9", 1200, 0, 0, 1, 0);
        cyc("s1fin", 1200, 0, 0, 0, 1);
        cyc("s1idle", 1200, 0, 0, 0, 0);
        cyc("s1idle2", 1200, 0, 0, 0, 0);

        // 2: down-sweep 500 -> 200 step 100, dwell 0 (one cycle per point)
        set_cfg(25'd500, 25'd200, 25'd100, 24'd0, 1'b0, 12'h001);
        pulse_start();
        cyc("s2c1", 500, 1, 1, 1, 0);
        cyc("s2c2", 400, 1, 0, 1, 0);
        cyc("s2c3", 300, 1, 0, 1, 0);
        cyc("s2c4", 200, 1, 0, 1, 0);
        cyc("s2fin", 200, 0, 0, 0, 1);
        cyc("s2idle", 200, 0, 0, 0, 0);

        // 3: carry out of the top bit ends the sweep after one point
        set_cfg(25'h1FFFFF0, 25'h1FFFFFF, 25'h20, 24'd1, 1'b0, 12'h002);
        pulse_start();
        cyc("s3c1", 32'h1FFFFF0, 1, 1, 1, 0);
        cyc("s3fin", 32'h1FFFFF0, 0, 0, 0, 1);
        cyc("s3idle", 32'h1FFFFF0, 0, 0, 0, 0);

        // 4: loop mode 10 -> 30 step 10, dwell 2; phase_cfg input changed mid-sweep
        set_cfg(25'd10, 25'd30, 25'd10, 24'd2, 1'b1, 12'h3C3);
        pulse_start();
        phase_cfg = 12'h111;
        cyc("s4c1", 10, 1, 1, 1, 0);
        cyc("s4c2", 10, 0, 0, 1, 0);
        cyc("s4c3", 20, 1, 0, 1, 0);
        cyc("s4c4", 20, 0, 0, 1, 0);
        cyc("s4c5", 30, 1, 0, 1, 0);
        cyc("s4c6", 30, 0, 0, 1, 0);
        chk("s4.reload_phase", 32'(init_phase), 32'h3C3);
        cyc("s4c7", 10, 1, 1, 1, 0);
        cyc("s4c8", 10, 0, 0, 1, 0);
        cyc("s4c9", 20, 1, 0, 1, 0);
        cyc("s4c10", 20, 0, 0, 1, 0);
        cyc("s4c11", 30, 1, 0, 1, 0);
        abort = 1'b1;                       // coincides with the dwell expiry
        cyc("s4c12", 30, 0, 0, 1, 0);
        abort = 1'b0;
        cyc("s4abort", 0, 0, 0, 0, 0);
        cyc("s4idle", 0, 0, 0, 0, 0);

        // 5: abort on the second point of scenario 1, then start+abort in IDLE
        set_cfg(25'd1000, 25'd1250, 25'd100, 24'd3, 1'b0, 12'h0F0);
        pulse_start();
        cyc("s5c1", 1000, 1, 1, 1, 0);
        cyc("s5c2", 1000, 0, 0, 1, 0);
        cyc("s5c3", 1000, 0, 0, 1, 0);
        cyc("s5c4", 1100, 1, 0, 1, 0);
        abort = 1'b1;
        cyc("s5c5", 1100, 0, 0, 1, 0);
        abort = 1'b0;
        cyc("s5abort", 0, 0, 0, 0, 0);
        cyc("s5idle", 0, 0, 0, 0, 0);
        chk("s5.init_phase_hold", 32'(init_phase), 32'h0F0);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk_100M);
        start = 1'b0;
        abort = 1'b0;
        cyc("s5both1", 0, 0, 0, 0, 0);
        cyc("s5both2", 0, 0, 0, 0, 0);

        // 6: asynchronous reset mid-sweep, then a fresh sweep with a start while busy
        set_cfg(25'd1000, 25'd1250, 25'd100, 24'd3, 1'b0, 12'h123);
        pulse_start();
        cyc("s6c1", 1000, 1, 1, 1, 0);
        cyc("s6c2", 1000, 0, 0, 1, 0);
        cyc("s6c3", 1000, 0, 0, 1, 0);
        chk("s6.pre_rst_fre", 32'(fre), 32'd1100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6rst.fre",        32'(fre),        32'd0);
        chk("s6rst.busy",       32'(busy),       32'd0);
        chk("s6rst.step_tick",  32'(step_tick),  32'd0);
        chk("s6rst.init_phase", 32'(init_phase), 32'd0);
        @(negedge clk_100M);
        rst_n = 1'b1;
        cyc("s6post", 0, 0, 0, 0, 0);
        set_cfg(25'd2000, 25'd2300, 25'd150, 24'd2, 1'b0, 12'h456);
        pulse_start();
        chk("s6b.init_phase", 32'(init_phase), 32'h456);
        cyc("s6b1", 2000, 1, 1, 1, 0);
        set_cfg(25'd9, 25'd9, 25'd1, 24'd7, 1'b1, 12'h777);
        start = 1'b1;                       // ignored while busy
        cyc("s6b2", 2000, 0, 0, 1, 0);
        start = 1'b0;
        cyc("s6b3", 2150, 1, 0, 1, 0);
        cyc("s6b4", 2150, 0, 0, 1, 0);
        cyc("s6b5", 2300, 1, 0, 1, 0);
        cyc("s6b6", 2300, 0, 0, 1, 0);
        cyc("s6bfin", 2300, 0, 0, 0, 1);
        cyc("s6bidle", 2300, 0, 0, 0, 0);
        chk("s6b.init_phase_hold", 32'(init_phase), 32'h456);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer for the triangle/sine DDS phase-accumulator cores, driven from the same 100 MHz clock.
- Drives the core's frequency word, initial phase and phase-reset pulse.
- Steps the frequency linearly from a start value toward a stop value, holding each point for a programmable dwell time.
- Runs as a single sweep or a continuous loop.
- Sits between the control/register interface and a DDS core instance.

Parameters:
FRE_W, 25, frequency-word width (matches the DDS fre input)
PH_W, 12, initial-phase width (matches the DDS init_phase input)
DWELL_W, 24, dwell counter width (clk_100M cycles per point)

Ports:
clk_100M  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; begins a sweep when idle
abort  in  1  one-cycle request; stops any sweep immediately
loop_en  in  1  0 = single sweep, 1 = restart at f_start after the last point
f_start  in  FRE_W  first frequency word
f_stop  in  FRE_W  frequency bound (upper bound for up-sweep, lower bound for down-sweep)
f_step  in  FRE_W  step magnitude
dwell  in  DWELL_W  cycles per point; 0 is treated as 1
phase_cfg  in  PH_W  initial phase applied at every sweep (re)start
fre  out  FRE_W  frequency word to the DDS core
init_phase  out  PH_W  initial phase to the DDS core
phase_rst  out  1  one-cycle phase-accumulator clear
busy  out  1  sweep in progress
step_tick  out  1  one-cycle pulse on every fre load
done  out  1  one-cycle pulse at the end of a single sweep

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state IDLE, shadow registers 0. Reset is honoured in every state, including mid-sweep.
- States: IDLE, LOAD, DWELL, STEP, FIN.
- IDLE:
  - start=1 and abort=0 latches f_start, f_stop, f_step, dwell, loop_en and phase_cfg into shadow registers, then goes to LOAD.
  - Inputs changing while busy have no effect until the next start.
  - start while busy is ignored.
- Direction: up if f_start <= f_stop, down otherwise. Fixed for the whole sweep.
- LOAD (1 cycle, registered):
  - Outputs: fre = f_start, init_phase = phase_cfg, phase_rst = 1, step_tick = 1, busy = 1. All are visible the cycle after start is sampled.
  - Then goes to DWELL.
- DWELL:
  - D = max(dwell, 1). fre is held exactly D cycles, counted from the cycle it first appears.
  - When the count expires, compute nxt in FRE_W+1 bits:
    - up: nxt = fre + f_step; last point if nxt > f_stop or carry out is set.
    - down: nxt = fre - f_step; last point if a borrow occurs or nxt < f_stop.
    - f_step = 0: the current point is always the last point.
  - Not last point: go to STEP.
  - Last point with loop_en = 0: go to FIN.
  - Last point with loop_en = 1: go to LOAD (phase_rst fires again; no done pulse).
- STEP (1 cycle): fre = nxt, step_tick = 1, then back to DWELL. The STEP cycle is counted as the first dwell cycle of the new point, so point spacing is exactly D cycles.
- FIN (1 cycle): done = 1, busy = 0, fre keeps the last point value, then IDLE.
- Frequencies emitted are always within [min(start, stop), max(start, stop)]. f_stop itself is emitted only when it is reachable exactly by stepping.
- abort:
  - In any non-IDLE state, abort goes to IDLE next cycle with fre = 0, busy = 0, phase_rst = 0 and no done pulse.
  - abort wins over a simultaneous start and over a simultaneous dwell expiry.
- Pulse outputs: phase_rst, step_tick and done are high for exactly one cycle each, and never high outside the conditions above.
- init_phase holds its value after the sweep ends or is aborted.

Decomposition:
- Shared package dds_ctrl_pkg:
  - state encoding (IDLE, LOAD, DWELL, STEP, FIN)
  - FRE_W and PH_W defaults, also reused by the DDS cores
  - DWELL_W default
- One sub-module, dds_dwell_cnt:
  - loadable down-counter with a zero→1 clamp
  - reload input, expire pulse output
  - asynchronous active-low reset
- Next-frequency arithmetic and the compare/carry logic stay in the top level.

Test Plan:
1. Up-sweep, loop_en=0: f_start=1000, f_stop=1250, f_step=100, dwell=3 → fre 1000, 1100, 1200, each held 3 cycles; 3 step_tick pulses; 1 phase_rst; done 1 cycle after the 1200 hold; busy low from then on; fre stays 1200.
2. Down-sweep with exact endpoint: f_start=500, f_stop=200, f_step=100, dwell=0 → fre 500, 400, 300, 200, one cycle each; done follows; 1250-type overshoot never appears.
3. Overflow edge: f_start=0x1FFFFF0, f_stop=0x1FFFFFF, f_step=0x20 → single point 0x1FFFFF0, then done; no wrap to a small value.
4. Loop mode: f_start=10, f_stop=30, f_step=10, dwell=2, loop_en=1 → sequence 10, 20, 30, 10, … with phase_rst at every 10 load; done is never asserted; busy stays high.
5. Abort mid-DWELL on the second point of scenario 1 → next cycle fre=0, busy=0, no done. A start asserted together with abort in IDLE is ignored.
6. Asynchronous reset mid-sweep → outputs 0 immediately; after release, start with new config behaves as in scenario 1. A start pulse during busy has no effect.
